multicycle_controller: RTL and testbench

Control unit for the multi-cycle MIPS datapath, the successor to the single-cycle controller. It is a Moore FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Memory wait states are configurable, and bne is an optional mode. It sits between the IR fields (opcode/func), the ALU zero flag, and the datapath muxes, register enables and unified memory.

---
 rtl/multicycle_controller.sv | 276 +++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: Moore FSM stepping each instruction through
// FETCH / DECODE / EXEC / MEM / WB with configurable memory wait states.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   opcode, func      IR[31:26] / IR[5:0], stable from DECODE onward
//   zero              ALU zero flag, used only in BRANCH
//   PCWrite, PCWriteCond, pc_en      PC load controls (pc_en combines zero)
//   IorD, MemRead, MemWrite, IRWrite unified memory / IR controls
//   RegWrite, RegDst, RegData        register file write controls
//   ALUSrcA, ALUSrcB, ALUop, PCSrc   datapath mux / ALU selects
//   instr_done        pulse on the final cycle of each instruction
//   illegal           pulse in DECODE for an unsupported opcode/func
//   state             current state encoding (debug)
module multicycle_controller #(
  parameter int unsigned MEM_LAT = 0,
  parameter int unsigned CNT_W   = 4,
  parameter bit          EN_BNE  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] RegDst,
  output logic [1:0] RegData,
  output logic [1:0] PCSrc,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LAT);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  // Instruction field decode; the IR is stable from DECODE onward.
  logic is_r, f_add, f_sub, f_and, f_or, f_slt, f_jr, r_alu;
  logic op_addi, op_slti, op_lw, op_sw, op_beq, op_bne, op_j, op_jal;
  logic is_bne, wait_done;

  assign is_r    = (opcode == OP_RTYPE);
  assign f_add   = (func == FN_ADD);
  assign f_sub   = (func == FN_SUB);
  assign f_and   = (func == FN_AND);
  assign f_or    = (func == FN_OR);
  assign f_slt   = (func == FN_SLT);
  assign f_jr    = (func == FN_JR);
  assign r_alu   = f_add | f_sub | f_and | f_or | f_slt;
  assign op_addi = (opcode == OP_ADDI);
  assign op_slti = (opcode == OP_SLTI);
  assign op_lw   = (opcode == OP_LW);
  assign op_sw   = (opcode == OP_SW);
  assign op_beq  = (opcode == OP_BEQ);
  assign op_bne  = EN_BNE && (opcode == OP_BNE);
  assign op_j    = (opcode == OP_J);
  assign op_jal  = (opcode == OP_JAL);
  assign is_bne  = op_bne;

  assign wait_done = (wcnt_q == WAIT_LAST);

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state and Moore output decode; everything is forced low during reset.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = '0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    RegDst      = 2'b00;
    RegData     = 2'b00;
    PCSrc       = 2'b00;
    instr_done  = 1'b0;
    illegal     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (wait_done) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (is_r && r_alu)              state_d = S_R_EXEC;
        else if (is_r && f_jr)          state_d = S_JR;
        else if (op_addi || op_slti)    state_d = S_I_EXEC;
        else if (op_lw || op_sw)        state_d = S_MEM_ADDR;
        else if (op_beq || op_bne)      state_d = S_BRANCH;
        else if (op_j)                  state_d = S_JUMP;
        else if (op_jal)                state_d = S_JAL;
        else begin
          // Unsupported encoding retires as a nop.
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        if (f_sub || f_slt) ALUop = 2'b01;
        else if (f_and)     ALUop = 2'b10;
        else if (f_or)      ALUop = 2'b11;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegDst     = 2'b01;
        RegWrite   = 1'b1;
        RegData    = f_slt ? 2'b10 : 2'b00;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = op_slti ? 2'b01 : 2'b00;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        RegWrite   = 1'b1;
        RegData    = op_slti ? 2'b10 : 2'b00;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = op_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (wait_done) state_d = S_MEM_WB;
        else           wcnt_d  = wcnt_q + CNT_W'(1);
      end
      S_MEM_WB: begin
        RegData    = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (wait_done) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b11;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        RegDst     = 2'b10;
        RegData    = 2'b11;
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUop       = 2'b00;
      RegDst      = 2'b00;
      RegData     = 2'b00;
      PCSrc       = 2'b00;
      instr_done  = 1'b0;
      illegal     = 1'b0;
    end

    // bne inverts the sense of zero for the conditional PC load.
    pc_en = PCWrite | (PCWriteCond & (zero ^ is_bne));
    state = rst ? 4'd0 : 4'(state_q);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam int NDUT = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 2 : 3;
  endfunction

  function automatic bit bne_of(input int g);
    return (g != 0);
  endfunction

  typedef struct packed {
    logic       pcw, pcwc, pce, iord, mr, mw, irw, rw, srca;
    logic [1:0] srcb, aluop, regdst, regdata, pcsrc;
    logic       done, ill;
  } ctl_t;

  typedef struct packed {
    ctl_t        c;
    logic        in_rst;
    logic [15:0] tag;
  } exp_t;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_SLT = 4, K_JR = 5,
                 K_ADDI = 6, K_SLTI = 7, K_LW = 8, K_SW = 9, K_BEQ = 10, K_BNE = 11,
                 K_J = 12, K_JAL = 13, K_ILL = 14;

  logic            clk = 1'b0;
  logic            rst_cur;
  logic [5:0]      opcode, func;
  logic            zero;
  logic [NDUT-1:0] rst_v;
  ctl_t            outs [NDUT];
  logic [3:0]      stv  [NDUT];

  int cur = 0;
  int lat = 0;
  bit enb = 1'b0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail_direct = 0;
  exp_t expq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic       pcw, pcwc, pce, iord, mr, mw, irw, rw, srca, done, ill;
    logic [1:0] srcb, aluop, regdst, regdata, pcsrc;
    logic [3:0] st;

    assign rst_v[g] = (cur != g) || rst_cur;

    multicycle_controller #(
      .MEM_LAT(lat_of(g)),
      .CNT_W  (4),
      .EN_BNE (bne_of(g))
    ) u_dut (
      .clk        (clk),
      .rst        (rst_v[g]),
      .opcode     (opcode),
      .func       (func),
      .zero       (zero),
      .PCWrite    (pcw),
      .PCWriteCond(pcwc),
      .pc_en      (pce),
      .IorD       (iord),
      .MemRead    (mr),
      .MemWrite   (mw),
      .IRWrite    (irw),
      .RegWrite   (rw),
      .ALUSrcA    (srca),
      .ALUSrcB    (srcb),
      .ALUop      (aluop),
      .RegDst     (regdst),
      .RegData    (regdata),
      .PCSrc      (pcsrc),
      .instr_done (done),
      .illegal    (ill),
      .state      (st)
    );

    assign outs[g] = {pcw, pcwc, pce, iord, mr, mw, irw, rw, srca,
                      srcb, aluop, regdst, regdata, pcsrc, done, ill};
    assign stv[g]  = st;
  end

  // Instruction class straight from the MIPS encoding table.
  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn, input bit en_bne);
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: return K_ADD;
          6'b100010: return K_SUB;
          6'b100100: return K_AND;
          6'b100101: return K_OR;
          6'b101010: return K_SLT;
          6'b001000: return K_JR;
          default:   return K_ILL;
        endcase
      end
      6'b001000: return K_ADDI;
      6'b001010: return K_SLTI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000101: return en_bne ? K_BNE : K_ILL;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  // Monitor: every cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    ctl_t got;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        got = outs[cur];
        n_checks++;
        if (got === e.c && (!e.in_rst || stv[cur] == 4'd0)) begin
          n_pass++;
        end else begin
          $display("FAIL ctl dut%0d op/fn/cyc=%h rst=%0b: got %h state %0d, expected %h",
                   cur, e.tag, e.in_rst, got, stv[cur], e.c);
        end
      end
    end
  end

  // Build the expected per-cycle control words for one instruction, queue them,
  // then drive the inputs cycle by cycle.  rst_at >= 0 pulses reset at that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zforce, input int rst_at);
    ctl_t seq[$];
    logic zs[$];
    ctl_t c;
    exp_t e;
    int   kind;
    int   n;
    logic bne_op;
    kind   = kind_of(op, fn, enb);
    bne_op = (op == 6'b000101);

    for (int i = 0; i <= lat; i++) begin
      c = '0; c.mr = 1'b1; c.srcb = 2'b01;
      if (i == lat) begin c.irw = 1'b1; c.pcw = 1'b1; end
      seq.push_back(c);
    end
    c = '0; c.srcb = 2'b11;
    if (kind == K_ILL) begin c.ill = 1'b1; c.done = 1'b1; end
    seq.push_back(c);

    case (kind)
      K_ADD, K_SUB, K_AND, K_OR, K_SLT: begin
        c = '0; c.srca = 1'b1;
        c.aluop = (kind == K_SUB || kind == K_SLT) ? 2'b01 :
                  (kind == K_AND) ? 2'b10 : (kind == K_OR) ? 2'b11 : 2'b00;
        seq.push_back(c);
        c = '0; c.regdst = 2'b01; c.rw = 1'b1; c.done = 1'b1;
        c.regdata = (kind == K_SLT) ? 2'b10 : 2'b00;
        seq.push_back(c);
      end
      K_ADDI, K_SLTI: begin
        c = '0; c.srca = 1'b1; c.srcb = 2'b10;
        c.aluop = (kind == K_SLTI) ? 2'b01 : 2'b00;
        seq.push_back(c);
        c = '0; c.rw = 1'b1; c.done = 1'b1;
        c.regdata = (kind == K_SLTI) ? 2'b10 : 2'b00;
        seq.push_back(c);
      end
      K_LW: begin
        c = '0; c.srca = 1'b1; c.srcb = 2'b10; seq.push_back(c);
        for (int i = 0; i <= lat; i++) begin
          c = '0; c.iord = 1'b1; c.mr = 1'b1; seq.push_back(c);
        end
        c = '0; c.regdata = 2'b01; c.rw = 1'b1; c.done = 1'b1; seq.push_back(c);
      end
      K_SW: begin
        c = '0; c.srca = 1'b1; c.srcb = 2'b10; seq.push_back(c);
        for (int i = 0; i <= lat; i++) begin
          c = '0; c.iord = 1'b1; c.mw = 1'b1; c.done = (i == lat); seq.push_back(c);
        end
      end
      K_BEQ, K_BNE: begin
        c = '0; c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01; c.done = 1'b1;
        seq.push_back(c);
      end
      K_J: begin
        c = '0; c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1; seq.push_back(c);
      end
      K_JR: begin
        c = '0; c.pcw = 1'b1; c.pcsrc = 2'b11; c.done = 1'b1; seq.push_back(c);
      end
      K_JAL: begin
        c = '0; c.regdst = 2'b10; c.regdata = 2'b11; c.rw = 1'b1;
        c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1; seq.push_back(c);
      end
      default: ;
    endcase

    for (int k = 0; k < seq.size(); k++) begin
      zs.push_back((zforce < 0) ? 1'($urandom) : 1'(zforce));
      c = seq[k];
      c.pce = c.pcw | (c.pcwc & (zs[k] ^ bne_op));
      seq[k] = c;
    end

    n = seq.size();
    if (rst_at >= 0 && rst_at < n) n = rst_at + 1;
    for (int k = 0; k < n; k++) begin
      e.in_rst = (k == rst_at);
      e.c      = e.in_rst ? ctl_t'('0) : seq[k];
      e.tag    = {op, fn, 4'(k)};
      expq.push_back(e);
    end

    for (int k = 0; k < n; k++) begin
      rst_cur = (k == rst_at);
      zero    = zs[k];
      if (k <= lat) begin
        opcode = 6'($urandom);
        func   = 6'($urandom);
      end else begin
        opcode = op;
        func   = fn;
      end
      @(posedge clk); #1;
    end
    rst_cur = 1'b0;
  endtask

  // Switch to another DUT instance and hold it in reset for two checked cycles.
  task automatic select_dut(input int g);
    exp_t e;
    cur     = g;
    lat     = lat_of(g);
    enb     = bne_of(g);
    rst_cur = 1'b1;
    for (int k = 0; k < 2; k++) begin
      e.c = '0; e.in_rst = 1'b1; e.tag = 16'hFFF0 + 16'(k);
      expq.push_back(e);
    end
    repeat (2) begin
      opcode = 6'($urandom);
      func   = 6'($urandom);
      zero   = 1'($urandom);
      @(posedge clk); #1;
    end
    rst_cur = 1'b0;
    if (stv[cur] !== 4'd0) begin
      n_fail_direct++;
      $display("FAIL dut%0d not in FETCH after reset: state %0d", cur, stv[cur]);
    end
  endtask

  task automatic run_random();
    logic [5:0] op, fn;
    int r, ra;
    r  = int'($urandom_range(0, 15));
    fn = 6'($urandom);
    op = 6'b000000;
    case (r)
      0:  fn = 6'b100000;
      1:  fn = 6'b100010;
      2:  fn = 6'b100100;
      3:  fn = 6'b100101;
      4:  fn = 6'b101010;
      5:  fn = 6'b001000;
      6:  op = 6'b001000;
      7:  op = 6'b001010;
      8:  op = 6'b100011;
      9:  op = 6'b101011;
      10: op = 6'b000100;
      11: op = 6'b000101;
      12: op = 6'b000010;
      13: op = 6'b000011;
      14: fn = 6'b100001;
      default: op = 6'($urandom);
    endcase
    ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 12)) : -1;
    run_instr(op, fn, -1, ra);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_cur = 1'b1;
    opcode  = '0;
    func    = '0;
    zero    = 1'b0;
    @(posedge clk); #1;

    // MEM_LAT=0, bne disabled
    select_dut(0);
    run_instr(6'b000000, 6'b100000, -1, -1);  // add
    run_instr(6'b000000, 6'b100010, -1, -1);  // sub
    run_instr(6'b000000, 6'b101010, -1, -1);  // slt
    run_instr(6'b000000, 6'b100100, -1, -1);  // and
    run_instr(6'b000000, 6'b100101, -1, -1);  // or
    run_instr(6'b000000, 6'b001000, -1, -1);  // jr
    run_instr(6'b001000, 6'b010101, -1, -1);  // addi
    run_instr(6'b001010, 6'b101010, -1, -1);  // slti
    run_instr(6'b000100, 6'b000000,  1, -1);  // beq taken
    run_instr(6'b000100, 6'b000000,  0, -1);  // beq not taken
    run_instr(6'b000101, 6'b000000,  0, -1);  // bne -> illegal here
    run_instr(6'b111111, 6'b000000, -1, -1);  // illegal opcode
    run_instr(6'b000000, 6'b100001, -1, -1);  // illegal func
    run_instr(6'b000010, 6'b000000, -1, -1);  // j
    run_instr(6'b000011, 6'b000000, -1, -1);  // jal
    run_instr(6'b100011, 6'b000000, -1, -1);  // lw
    run_instr(6'b101011, 6'b000000, -1, -1);  // sw
    repeat (50) run_random();

    // MEM_LAT=2, bne enabled
    select_dut(1);
    run_instr(6'b100011, 6'b000000, -1, -1);  // lw
    run_instr(6'b000101, 6'b000000,  0, -1);  // bne taken
    run_instr(6'b000101, 6'b000000,  1, -1);  // bne not taken
    run_instr(6'b000100, 6'b000000,  1, -1);  // beq taken
    run_instr(6'b101011, 6'b000000, -1, -1);  // sw
    repeat (50) run_random();

    // MEM_LAT=3: reset in the second MEM_WR cycle of sw
    select_dut(2);
    run_instr(6'b101011, 6'b000000, -1, 7);
    run_instr(6'b000000, 6'b100000, -1, -1);
    run_instr(6'b100011, 6'b000000, -1, 2);   // reset during a fetch wait cycle
    run_instr(6'b100011, 6'b000000, -1, -1);
    repeat (50) run_random();

    @(negedge clk);
    @(negedge clk);
    if (n_checks < 12) begin
      n_fail_direct++;
      $display("FAIL only %0d checks executed", n_checks);
    end
    if (n_pass != n_checks || n_fail_direct != 0) begin
      $display("FAIL %0d/%0d checks passed, %0d direct failures",
               n_pass, n_checks, n_fail_direct);
    end else begin
      $display("PASS %0d/%0d checks passed", n_pass, n_checks);
    end
    $finish;
  end

endmodule
